// File: rtl/utlb_pkg.sv
// Shared types and constants for the utlb_front micro-TLB.
package utlb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOOKUP = 1'b1
  } utlb_state_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic        uncached;
  } utlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        uncached;
  } utlb_result_t;

  localparam logic [1:0] KSEG_UNMAPPED = 2'b10;

  // Direct-mapped segment: strip the top three bits, bit 29 selects uncached.
  function automatic utlb_result_t unmapped_result(input logic [31:0] vaddr);
    utlb_result_t r;
    r.paddr    = {3'b000, vaddr[28:0]};
    r.miss     = 1'b0;
    r.invalid  = 1'b0;
    r.uncached = vaddr[29];
    return r;
  endfunction

endpackage

// File: rtl/utlb_match.sv
// Parallel VPN compare across all micro-TLB entries; returns hit and hit index.
module utlb_match
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]       valid,
  input  logic [ENTRIES-1:0][19:0] vpn_table,
  input  logic [19:0]              vpn,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx
);

  logic [ENTRIES-1:0] match_s;

  // Entries never hold duplicate VPNs, so OR-ing the matching indices is exact.
  always_comb begin
    match_s = '0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_s[i] = valid[i] && (vpn_table[i] == vpn);
      hit_idx    = hit_idx | (match_s[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

  assign hit = |match_s;

endmodule

// File: rtl/utlb_front.sv
// Micro-TLB front end with round-robin fill from the main TLB.
// Optional UTLB_PERF_EN adds saturating hit/miss counters.
module utlb_front
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic        resp_miss,
  output logic        resp_invalid,
  output logic        resp_uncached,
  input  logic        flush,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_valid,
  input  logic        tlb_uncached
`ifdef UTLB_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  utlb_state_t               state_r, state_nxt_s;
  utlb_entry_t [ENTRIES-1:0] entries_r;
  logic [IDX_W-1:0]          ptr_r;
  logic [31:0]               held_vaddr_r;
  utlb_result_t              resp_r;
  logic                      resp_valid_r;
  logic [ENTRIES-1:0]        valid_s;
  logic [ENTRIES-1:0][19:0]  vpn_s;
  logic                      hit_s;
  logic [IDX_W-1:0]          hit_idx_s;
  logic                      unmapped_s, accept_s, start_lookup_s, fill_s;

  always_comb begin
    valid_s = '0;
    vpn_s   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_s[i] = entries_r[i].valid;
      vpn_s[i]   = entries_r[i].vpn;
    end
  end

  utlb_match #(.ENTRIES(ENTRIES)) u_match (
    .valid     (valid_s),
    .vpn_table (vpn_s),
    .vpn       (req_vaddr[31:12]),
    .hit       (hit_s),
    .hit_idx   (hit_idx_s)
  );

  assign unmapped_s = (req_vaddr[31:30] == KSEG_UNMAPPED);
  assign fill_s     = (state_r == LOOKUP) && !tlb_miss && tlb_valid && !flush;

  always_comb begin
    state_nxt_s    = state_r;
    req_ready      = 1'b0;
    accept_s       = 1'b0;
    start_lookup_s = 1'b0;
    tlb_vaddr      = req_vaddr;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        accept_s  = req_valid;
        if (req_valid && !unmapped_s && !hit_s) begin
          start_lookup_s = 1'b1;
          state_nxt_s    = LOOKUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOOKUP: begin
        tlb_vaddr   = held_vaddr_r;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // Responses, held address, entry table and victim pointer; flush beats fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entries_r    <= '0;
      ptr_r        <= '0;
      held_vaddr_r <= 32'h0000_0000;
      resp_r       <= '0;
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      if (start_lookup_s) begin
        held_vaddr_r <= req_vaddr;
      end else if (accept_s) begin
        resp_valid_r <= 1'b1;
        if (unmapped_s) begin
          resp_r <= unmapped_result(req_vaddr);
        end else begin
          resp_r <= '{paddr:    {entries_r[hit_idx_s].pfn, req_vaddr[11:0]},
                      miss:     1'b0,
                      invalid:  1'b0,
                      uncached: entries_r[hit_idx_s].uncached};
        end
      end else if (state_r == LOOKUP) begin
        resp_valid_r <= 1'b1;
        resp_r <= '{paddr:    tlb_paddr,
                    miss:     tlb_miss,
                    invalid:  !tlb_miss && !tlb_valid,
                    uncached: tlb_uncached};
      end
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          entries_r[i].valid <= 1'b0;
        end
      end else if (fill_s) begin
        entries_r[ptr_r] <= '{valid:    1'b1,
                              vpn:      held_vaddr_r[31:12],
                              pfn:      tlb_paddr[31:12],
                              uncached: tlb_uncached};
        ptr_r <= ptr_r + IDX_W'(1);
      end
    end
  end

  assign resp_valid    = resp_valid_r;
  assign resp_paddr    = resp_r.paddr;
  assign resp_miss     = resp_r.miss;
  assign resp_invalid  = resp_r.invalid;
  assign resp_uncached = resp_r.uncached;

`ifdef UTLB_PERF_EN
  logic [31:0] hit_count_r, miss_count_r;

  // Saturating counters: mapped hits, and every entry into LOOKUP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_r  <= 32'h0000_0000;
      miss_count_r <= 32'h0000_0000;
    end else begin
      if (accept_s && !unmapped_s && hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (start_lookup_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_utlb_front.sv
// Scoreboard bench for utlb_front: directed requests push expected results, a monitor checks responses.
module tb_utlb_front;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_vaddr = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_miss, resp_invalid, resp_uncached;
  logic        flush = 1'b0;
  logic [31:0] tlb_vaddr;
  logic [31:0] tlb_paddr = 32'h0;
  logic        tlb_miss = 1'b0, tlb_valid = 1'b0, tlb_uncached = 1'b0;
`ifdef UTLB_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  utlb_front #(.ENTRIES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_vaddr     (req_vaddr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_paddr    (resp_paddr),
    .resp_miss     (resp_miss),
    .resp_invalid  (resp_invalid),
    .resp_uncached (resp_uncached),
    .flush         (flush),
    .tlb_vaddr     (tlb_vaddr),
    .tlb_paddr     (tlb_paddr),
    .tlb_miss      (tlb_miss),
    .tlb_valid     (tlb_valid),
    .tlb_uncached  (tlb_uncached)
`ifdef UTLB_PERF_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] paddr;
    logic        miss;
    logic        inv;
    logic        unc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_pass = 0;
  int n_total = 0;

  localparam logic [31:0] GP = 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_paddr",    resp_paddr,            mon_e.paddr);
        chk("resp_miss",     32'(resp_miss),        32'(mon_e.miss));
        chk("resp_invalid",  32'(resp_invalid),     32'(mon_e.inv));
        chk("resp_uncached", 32'(resp_uncached),    32'(mon_e.unc));
        chk("resp_cycle",    32'(cyc),              32'(mon_e.cyc));
      end
    end
  end

  // fmode: 0 none, 1 flush in the accept cycle, 2 flush in the LOOKUP cycle.
  task automatic issue(input logic [31:0] va, input logic [31:0] tp, input logic tm,
                       input logic tv, input logic tu, input logic [31:0] ep,
                       input logic em, input logic ei, input logic eu,
                       input int lat, input int fmode);
    int   n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
    req_valid    = 1'b1;
    req_vaddr    = va;
    tlb_paddr    = tp;
    tlb_miss     = tm;
    tlb_valid    = tv;
    tlb_uncached = tu;
    flush        = (fmode == 1);
    e.paddr = ep; e.miss = em; e.inv = ei; e.unc = eu; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_vaddr = 32'hFFFF_F000;
    flush     = 1'b0;
    if (lat == 2) begin
      chk("tlb_vaddr", tlb_vaddr, va);
      flush = (fmode == 2);
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready",     32'(req_ready),     32'd1);
    chk("rst_resp_valid",    32'(resp_valid),    32'd0);
    chk("rst_resp_paddr",    resp_paddr,         32'd0);
    chk("rst_resp_miss",     32'(resp_miss),     32'd0);
    chk("rst_resp_invalid",  32'(resp_invalid),  32'd0);
    chk("rst_resp_uncached", 32'(resp_uncached), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Unmapped segment, main TLB inputs are garbage.
    issue(32'hA000_1234, GP, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 1, 0);
    issue(32'h8000_1234, GP, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1, 0);
    issue(32'hBFC0_0000, GP, 1'b1, 1'b0, 1'b1, 32'h1FC0_0000, 1'b0, 1'b0, 1'b1, 1, 0);
    // Mapped fill then hit.
    issue(32'h0040_3ABC, 32'h1F00_3ABC, 1'b0, 1'b1, 1'b0, 32'h1F00_3ABC, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h0040_3FFF, GP, 1'b1, 1'b0, 1'b1, 32'h1F00_3FFF, 1'b0, 1'b0, 1'b0, 1, 0);
    // Main TLB miss and invalid results are not cached.
    issue(32'h0080_0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2, 0);
    issue(32'h0080_0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2, 0);
    issue(32'h00C0_0000, 32'h1234_5000, 1'b0, 1'b0, 1'b0, 32'h1234_5000, 1'b0, 1'b1, 1'b0, 2, 0);
    issue(32'h00C0_0000, 32'h1234_5000, 1'b0, 1'b0, 1'b0, 32'h1234_5000, 1'b0, 1'b1, 1'b0, 2, 0);
    // Uncached mapped page.
    issue(32'h0100_0000, 32'h2A00_0000, 1'b0, 1'b1, 1'b1, 32'h2A00_0000, 1'b0, 1'b0, 1'b1, 2, 0);
    issue(32'h0100_0010, GP, 1'b1, 1'b0, 1'b0, 32'h2A00_0010, 1'b0, 1'b0, 1'b1, 1, 0);
    // Idle flush empties the table.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    issue(32'h0040_3ABC, 32'h1F00_3ABC, 1'b0, 1'b1, 1'b0, 32'h1F00_3ABC, 1'b0, 1'b0, 1'b0, 2, 0);
    // Five pages into four entries: the first of the five is evicted.
    for (int p = 0; p < 5; p++) begin
      issue(32'h1000_0010 + 32'(p) * 32'h1000, 32'h3000_0010 + 32'(p) * 32'h1000, 1'b0, 1'b1, 1'b0,
            32'h3000_0010 + 32'(p) * 32'h1000, 1'b0, 1'b0, 1'b0, 2, 0);
    end
    issue(32'h1000_0010, 32'h3000_0010, 1'b0, 1'b1, 1'b0, 32'h3000_0010, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h1000_4010, GP, 1'b1, 1'b0, 1'b0, 32'h3000_4010, 1'b0, 1'b0, 1'b0, 1, 0);
    issue(32'h1000_3010, GP, 1'b1, 1'b0, 1'b0, 32'h3000_3010, 1'b0, 1'b0, 1'b0, 1, 0);
    issue(32'h1000_2010, GP, 1'b1, 1'b0, 1'b0, 32'h3000_2010, 1'b0, 1'b0, 1'b0, 1, 0);
    // Request alongside flush sees pre-flush contents; afterwards it misses.
    issue(32'h1000_3010, GP, 1'b1, 1'b0, 1'b0, 32'h3000_3010, 1'b0, 1'b0, 1'b0, 1, 1);
    issue(32'h1000_3010, 32'h3000_3010, 1'b0, 1'b1, 1'b0, 32'h3000_3010, 1'b0, 1'b0, 1'b0, 2, 0);
    // Flush during LOOKUP: response still delivered, no fill.
    issue(32'h2000_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 2, 2);
    issue(32'h2000_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h2000_0004, GP, 1'b1, 1'b0, 1'b0, 32'h4000_0004, 1'b0, 1'b0, 1'b0, 1, 0);

    // Reset during LOOKUP abandons the request.
    req_valid = 1'b1;
    req_vaddr = 32'h3000_0000;
    tlb_paddr = 32'h5000_0000; tlb_miss = 1'b0; tlb_valid = 1'b1; tlb_uncached = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_lookup_vaddr", tlb_vaddr, 32'h3000_0000);
    chk("ready_in_lookup", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstl_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstl_resp_paddr", resp_paddr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstl_ready", 32'(req_ready), 32'd1);
    chk("rstl_resp_valid2", 32'(resp_valid), 32'd0);
    issue(32'h2000_0004, 32'h4000_0004, 1'b0, 1'b1, 1'b0, 32'h4000_0004, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h3000_0000, 32'h5000_0000, 1'b0, 1'b1, 1'b0, 32'h5000_0000, 1'b0, 1'b0, 1'b0, 2, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
